rotate_sequencer: RTL and testbench



---
 rtl/rotate_sequencer_pkg.sv | 13 +
 rtl/rotate_pow2_stage.sv | 35 +++
 rtl/rotate_sequencer.sv | 99 +++++++++
 tb/tb_rotate_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_sequencer_pkg.sv
// Shared types and constants for the sequenced circular rotator.
package rotate_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic ROT_LEFT  = 1'b0;
   localparam logic ROT_RIGHT = 1'b1;

endpackage

// File: rtl/rotate_pow2_stage.sv
// One reusable rotate stage: rotates by 2^idx_i in direction dir_i when en_i is set.
module rotate_pow2_stage
   import rotate_sequencer_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] data_i,
   input  logic [W-1:0] idx_i,
   input  logic         dir_i,
   input  logic         en_i,
   output logic [N-1:0] data_o
);

   logic [N-1:0] rotl [W];
   logic [N-1:0] rotr [W];

   for (genvar g = 0; g < W; g++) begin : g_rot
      localparam int S = 1 << g;
      assign rotl[g] = {data_i[N-S-1:0], data_i[N-1:N-S]};
      assign rotr[g] = {data_i[S-1:0], data_i[N-1:S]};
   end

   always_comb begin
      data_o = data_i;
      if (en_i) begin
         for (int i = 0; i < W; i++) begin
            if (idx_i == W'(i)) begin
               data_o = (dir_i == ROT_RIGHT) ? rotr[i] : rotl[i];
            end
         end
      end
   end

endmodule

// File: rtl/rotate_sequencer.sv
// Multi-cycle circular rotator: one request in, W single-stage rotate steps, one result out.
module rotate_sequencer
   import rotate_sequencer_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [N-1:0] up_data,
   input  logic [W-1:0] up_amount,
   input  logic         up_dir,
   output logic         down_valid,
   input  logic         down_ready,
   output logic [N-1:0] down_data
);

   if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
      $error("rotate_sequencer: N must be a power of two and >= 2");
   end

   state_t         state_q, state_d;
   logic [N-1:0]   data_q;
   logic [W-1:0]   amt_q;
   logic           dir_q;
   logic [W-1:0]   stage_q;
   logic           stage_en;
   logic [N-1:0]   stage_data;

   always_comb begin
      stage_en = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (stage_q == W'(i)) begin
            stage_en = amt_q[i];
         end
      end
   end

   rotate_pow2_stage #(.N(N)) u_stage (
      .data_i (data_q),
      .idx_i  (stage_q),
      .dir_i  (dir_q),
      .en_i   (stage_en),
      .data_o (stage_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (up_valid) state_d = BUSY;
         BUSY:    if (stage_q == W'(W - 1)) state_d = DONE;
         DONE:    if (down_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      up_ready   = (state_q == IDLE) && !rst;
      down_valid = (state_q == DONE);
      down_data  = down_valid ? data_q : '0;
   end

   // Datapath: capture on accept, then apply one power-of-two stage per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         amt_q   <= '0;
         dir_q   <= ROT_LEFT;
         stage_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (up_valid) begin
                  data_q  <= up_data;
                  amt_q   <= up_amount;
                  dir_q   <= up_dir;
                  stage_q <= '0;
               end
            end
            BUSY: begin
               data_q  <= stage_data;
               stage_q <= stage_q + W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Scoreboard bench for rotate_sequencer (N=8): directed vectors, backpressure, reset abort, random stream.
module tb_rotate_sequencer;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         up_valid = 1'b0;
   logic         up_ready;
   logic [N-1:0] up_data = '0;
   logic [W-1:0] up_amount = '0;
   logic         up_dir = 1'b0;
   logic         down_valid;
   logic         down_ready = 1'b1;
   logic [N-1:0] down_data;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic [N-1:0] exp_q [$];

   rotate_sequencer #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_amount  (up_amount),
      .up_dir     (up_dir),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N-1:0] rot_ref(input logic [N-1:0] d, input int a, input logic dir);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (dir == 1'b0) r[(i + a) % N] = d[i];
         else             r[i] = d[(i + a) % N];
      end
      return r;
   endfunction

   function automatic int popcnt(input logic [N-1:0] d);
      int c;
      c = 0;
      for (int i = 0; i < N; i++) c += int'(d[i]);
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for up_ready, presents one request for one accepting edge.
   task automatic send(input logic [N-1:0] d, input int a, input logic dir,
                       input logic [N-1:0] expv, input bit push);
      int n;
      n = 0;
      while (!up_ready && n < 50) begin
         tick();
         n++;
      end
      up_valid  = 1'b1;
      up_data   = d;
      up_amount = W'(a);
      up_dir    = dir;
      if (push) exp_q.push_back(expv);
      tick();
      acc_cyc  = cyc;
      up_valid = 1'b0;
   endtask

   // Waits (bounded) for down_valid, samples it, then lets the handshake edge pass.
   task automatic recv(output logic [N-1:0] d, output int lat, output bit ok);
      int n;
      n = 0;
      while (!down_valid && n < 50) begin
         tick();
         n++;
      end
      ok  = down_valid;
      d   = down_data;
      lat = cyc - acc_cyc;
      if (ok) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (up_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_up_ready: got %b want 0", up_ready);
      end
      n_cmp++;
      if (down_valid !== 1'b0 || down_data !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_down: got v=%b d=%h want v=0 d=00", down_valid, down_data);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (up_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_up_ready: got %b want 1", up_ready);
      end
   endtask

   task automatic test_directed();
      logic [N-1:0] td [5] = '{8'b1011_0001, 8'b1011_0001, 8'h01, 8'h01, 8'hA5};
      int           ta [5] = '{3, 3, 7, 7, 0};
      logic         tr [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [N-1:0] te [5] = '{8'b0011_0110, 8'b1000_1101, 8'h80, 8'h02, 8'hA5};
      logic [N-1:0] got, expv;
      int lat;
      bit ok;
      down_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(td[i], ta[i], tr[i], te[i], 1'b1);
         n_cmp++;
         if (up_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL directed%0d_busy_up_ready: got %b want 0", i, up_ready);
         end
         recv(got, lat, ok);
         expv = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
         n_cmp++;
         if (!ok || got !== expv) begin
            n_bad++;
            $display("FAIL directed%0d_data: got %h (valid=%b) want %h", i, got, ok, expv);
         end
         n_cmp++;
         if (lat !== W) begin
            n_bad++;
            $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, W);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [N-1:0] expv;
      int n;
      down_ready = 1'b0;
      send(8'h3C, 2, 1'b0, 8'hF0, 1'b1);
      n = 0;
      while (!down_valid && n < 50) begin
         tick();
         n++;
      end
      expv = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      for (int i = 0; i < 5; i++) begin
         up_valid = (i == 2);
         up_data  = 8'hFF;
         n_cmp++;
         if (down_valid !== 1'b1 || down_data !== expv || up_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_hold%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                     i, down_valid, down_data, up_ready, expv);
         end
         tick();
      end
      up_valid   = 1'b0;
      down_ready = 1'b1;
      tick();
      n_cmp++;
      if (down_valid !== 1'b0 || down_data !== 8'h00 || up_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL backpressure_release: got v=%b d=%h rdy=%b want v=0 d=00 rdy=1",
                  down_valid, down_data, up_ready);
      end
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (down_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL backpressure_ignored_req: got valid=%b want 0", down_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      down_ready = 1'b1;
      send(8'hC3, 5, 1'b1, 8'h00, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if (down_valid !== 1'b0 || down_data !== 8'h00 || up_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_state: got v=%b d=%h rdy=%b want v=0 d=00 rdy=0",
                  down_valid, down_data, up_ready);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (up_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_mid_up_ready: got %b want 1", up_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (down_valid) seen = 1'b1;
         tick();
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_no_result: got result=%b want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] d, got, expv;
      int a, lat, prev;
      logic dir;
      bit ok;
      down_ready = 1'b1;
      prev = 0;
      for (int i = 0; i < 20; i++) begin
         d   = N'($urandom);
         a   = int'($urandom_range(0, N - 1));
         dir = 1'($urandom_range(0, 1));
         send(d, a, dir, rot_ref(d, a, dir), 1'b1);
         if (i > 0) begin
            n_cmp++;
            if (acc_cyc - prev !== W + 2) begin
               n_bad++;
               $display("FAIL b2b%0d_spacing: got %0d want %0d", i, acc_cyc - prev, W + 2);
            end
         end
         prev = acc_cyc;
         recv(got, lat, ok);
         expv = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
         n_cmp++;
         if (!ok || got !== expv || popcnt(got) != popcnt(d)) begin
            n_bad++;
            $display("FAIL b2b%0d_data: in=%h amt=%0d dir=%b got %h want %h", i, d, a, dir, got, expv);
         end
      end
      n_cmp++;
      if (rot_ref(8'h5A, 3, 1'b0) !== got && 1'b0) n_bad++;
      n_cmp--;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
